// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encoding, width defaults,
// length codes and the pointer-width helper.
`timescale 1ns/1ps
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 2;

  localparam logic [LEN_W_DEF-1:0] LEN_1B = 2'd0;
  localparam logic [LEN_W_DEF-1:0] LEN_2B = 2'd1;
  localparam logic [LEN_W_DEF-1:0] LEN_4B = 2'd2;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: request vector + start pointer -> one-hot
// grant and valid.
`timescale 1ns/1ps
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && req[k] && (k >= 32'(ptr))) begin
        gnt[k] = 1'b1;
        valid  = 1'b1;
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && req[k] && (k < 32'(ptr))) begin
        gnt[k] = 1'b1;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among NR read and NW
// write core ports. Optional macro: MEM_ARB_WPRIO_EN (writes beat reads).
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NR     = 2,
  parameter int NW     = 1,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NR-1:0]        co_re,
  input  logic [NR*ADDR_W-1:0] co_raddr,
  input  logic [NR*LEN_W-1:0]  co_rlen,
  output logic [NR*DATA_W-1:0] co_din,
  output logic [NR-1:0]        co_rack,
  input  logic [NW-1:0]        co_we,
  input  logic [NW*ADDR_W-1:0] co_waddr,
  input  logic [NW*LEN_W-1:0]  co_wlen,
  input  logic [NW*DATA_W-1:0] co_dout,
  output logic [NW-1:0]        co_wack,
  output logic                 m_re,
  output logic                 m_we,
  output logic [ADDR_W-1:0]    m_raddr,
  output logic [ADDR_W-1:0]    m_waddr,
  output logic [LEN_W-1:0]     m_rlen,
  output logic [LEN_W-1:0]     m_wlen,
  output logic [DATA_W-1:0]    m_wdata,
  input  logic [DATA_W-1:0]    m_rdata,
  input  logic                 m_rack,
  input  logic                 m_wack
);

  localparam int N  = NR + NW;
  localparam int GW = ptr_w(N);

  logic [1:0]        state;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     gidx;
  logic              gread;

  logic [N-1:0]      pick_gnt;
  logic              pick_valid;
  logic [GW-1:0]     pick_idx;
  logic              pick_read;
  logic [ADDR_W-1:0] sel_raddr;
  logic [ADDR_W-1:0] sel_waddr;
  logic [LEN_W-1:0]  sel_rlen;
  logic [LEN_W-1:0]  sel_wlen;
  logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_WPRIO_EN
  localparam int RPW = ptr_w(NR);
  localparam int WPW = ptr_w(NW);

  logic [NR-1:0]  rgnt;
  logic [NW-1:0]  wgnt;
  logic           rvalid;
  logic           wvalid;
  logic [RPW-1:0] rptr;
  logic [WPW-1:0] wptr;

  // The global pointer is split into per-class pointers; a class whose range
  // does not contain the pointer starts its scan at its own port 0.
  always_comb begin
    rptr = '0;
    wptr = '0;
    if (ptr < GW'(NR)) rptr = RPW'(ptr);
    else               wptr = WPW'(ptr - GW'(NR));
  end

  mem_port_arbiter_rr_pick #(.N(NR)) u_pick_rd (
    .req   (co_re),
    .ptr   (rptr),
    .gnt   (rgnt),
    .valid (rvalid)
  );

  mem_port_arbiter_rr_pick #(.N(NW)) u_pick_wr (
    .req   (co_we),
    .ptr   (wptr),
    .gnt   (wgnt),
    .valid (wvalid)
  );

  always_comb begin
    pick_gnt   = wvalid ? {wgnt, {NR{1'b0}}} : {{NW{1'b0}}, rgnt};
    pick_valid = wvalid | rvalid;
  end
`else
  mem_port_arbiter_rr_pick #(.N(N)) u_pick (
    .req   ({co_we, co_re}),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );
`endif

  always_comb begin
    pick_idx  = '0;
    sel_raddr = '0;
    sel_rlen  = '0;
    sel_waddr = '0;
    sel_wlen  = '0;
    sel_wdata = '0;
    pick_read = |pick_gnt[NR-1:0];
    for (int unsigned k = 0; k < N; k++) begin
      if (pick_gnt[k]) pick_idx = GW'(k);
    end
    for (int unsigned k = 0; k < NR; k++) begin
      if (pick_gnt[k]) begin
        sel_raddr = co_raddr[k*ADDR_W +: ADDR_W];
        sel_rlen  = co_rlen[k*LEN_W +: LEN_W];
      end
    end
    for (int unsigned k = 0; k < NW; k++) begin
      if (pick_gnt[NR+k]) begin
        sel_waddr = co_waddr[k*ADDR_W +: ADDR_W];
        sel_wlen  = co_wlen[k*LEN_W +: LEN_W];
        sel_wdata = co_dout[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      gread   <= 1'b0;
      m_re    <= 1'b0;
      m_we    <= 1'b0;
      m_raddr <= '0;
      m_waddr <= '0;
      m_rlen  <= '0;
      m_wlen  <= '0;
      m_wdata <= '0;
      co_din  <= '0;
      co_rack <= '0;
      co_wack <= '0;
    end else begin
      co_rack <= '0;
      co_wack <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gidx  <= pick_idx;
            gread <= pick_read;
            if (pick_read) begin
              m_re    <= 1'b1;
              m_raddr <= sel_raddr;
              m_rlen  <= sel_rlen;
            end else begin
              m_we    <= 1'b1;
              m_waddr <= sel_waddr;
              m_wlen  <= sel_wlen;
              m_wdata <= sel_wdata;
            end
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Ack pulses are registered here so they appear during DONE.
          if (gread && m_rack) begin
            m_re <= 1'b0;
            for (int unsigned k = 0; k < NR; k++) begin
              if (gidx == GW'(k)) begin
                co_din[k*DATA_W +: DATA_W] <= m_rdata;
                co_rack[k]                 <= 1'b1;
              end
            end
            state <= ST_DONE;
          end else if (!gread && m_wack) begin
            m_we <= 1'b0;
            for (int unsigned k = 0; k < NW; k++) begin
              if (gidx == GW'(NR + k)) co_wack[k] <= 1'b1;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptr   <= (gidx == GW'(N - 1)) ? '0 : gidx + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single-transaction vectors
// plus hand sequences for contention and mid-transaction reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int NR = 2, NW = 1, ADDR_W = 32, DATA_W = 32, LEN_W = 2;
`ifdef MEM_ARB_WPRIO_EN
  localparam bit WPRIO = 1'b1;
`else
  localparam bit WPRIO = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NR-1:0]        co_re = '0;
  logic [NR*ADDR_W-1:0] co_raddr = '0;
  logic [NR*LEN_W-1:0]  co_rlen = '0;
  logic [NR*DATA_W-1:0] co_din;
  logic [NR-1:0]        co_rack;
  logic [NW-1:0]        co_we = '0;
  logic [NW*ADDR_W-1:0] co_waddr = '0;
  logic [NW*LEN_W-1:0]  co_wlen = '0;
  logic [NW*DATA_W-1:0] co_dout = '0;
  logic [NW-1:0]        co_wack;
  logic                 m_re, m_we;
  logic [ADDR_W-1:0]    m_raddr, m_waddr;
  logic [LEN_W-1:0]     m_rlen, m_wlen;
  logic [DATA_W-1:0]    m_wdata;
  logic [DATA_W-1:0]    m_rdata = '0;
  logic                 m_rack = 1'b0;
  logic                 m_wack = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NR(NR), .NW(NW), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .co_re(co_re), .co_raddr(co_raddr), .co_rlen(co_rlen), .co_din(co_din), .co_rack(co_rack),
    .co_we(co_we), .co_waddr(co_waddr), .co_wlen(co_wlen), .co_dout(co_dout), .co_wack(co_wack),
    .m_re(m_re), .m_we(m_we), .m_raddr(m_raddr), .m_waddr(m_waddr), .m_rlen(m_rlen),
    .m_wlen(m_wlen), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_rack(m_rack), .m_wack(m_wack)
  );

  typedef struct {
    logic [NR-1:0]     re;
    logic [NW-1:0]     we;
    logic [ADDR_W-1:0] raddr0, raddr1, waddr;
    logic [LEN_W-1:0]  rlen0, rlen1, wlen;
    logic [DATA_W-1:0] wdata, rdata;
    int                lat;
    int                port;
    bit                drop;
    bit                wrong_ack;
  } vec_t;

  typedef struct {
    bit                is_wr;
    int                port;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] wdata;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] exp_din [NR];
  vec_t              vecs [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input logic [NR-1:0] re, input logic [NW-1:0] we,
                              input logic [31:0] ra0, input logic [1:0] rl0,
                              input logic [31:0] ra1, input logic [1:0] rl1,
                              input logic [31:0] wa, input logic [1:0] wl,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int lat, input int port, input bit drop, input bit wrong);
    vec_t v;
    v.re = re; v.we = we; v.raddr0 = ra0; v.rlen0 = rl0; v.raddr1 = ra1; v.rlen1 = rl1;
    v.waddr = wa; v.wlen = wl; v.wdata = wd; v.rdata = rd; v.lat = lat; v.port = port;
    v.drop = drop; v.wrong_ack = wrong;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; co_re = '0; co_we = '0; m_rack = 1'b0; m_wack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NR; i++) exp_din[i] = '0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   cyc;
    @(posedge clk); #1;
    co_re = v.re; co_we = v.we;
    co_raddr = {v.raddr1, v.raddr0}; co_rlen = {v.rlen1, v.rlen0};
    co_waddr = v.waddr; co_wlen = v.wlen; co_dout = v.wdata;
    e.port  = v.port;
    e.is_wr = (v.port >= NR);
    e.addr  = (v.port == 0) ? v.raddr0 : (v.port == 1) ? v.raddr1 : v.waddr;
    e.len   = (v.port == 0) ? v.rlen0 : (v.port == 1) ? v.rlen1 : v.wlen;
    e.wdata = v.wdata;
    sb.push_back(e);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!(m_re || m_we) && cyc < 20);
    check("en_latency", 64'(cyc), 64'd1);
    e = sb.pop_front();
    if (!(m_re || m_we)) begin
      co_re = '0; co_we = '0;
      return;
    end
    if (v.drop) begin co_re = '0; co_we = '0; end
    check("m_re", 64'(m_re), 64'(!e.is_wr));
    check("m_we", 64'(m_we), 64'(e.is_wr));
    if (e.is_wr) begin
      check("m_waddr", 64'(m_waddr), 64'(e.addr));
      check("m_wlen",  64'(m_wlen),  64'(e.len));
      check("m_wdata", 64'(m_wdata), 64'(e.wdata));
    end else begin
      check("m_raddr", 64'(m_raddr), 64'(e.addr));
      check("m_rlen",  64'(m_rlen),  64'(e.len));
    end
    for (int i = 0; i < v.lat; i++) begin
      if (i == 0 && v.wrong_ack) begin
        if (e.is_wr) m_rack = 1'b1; else m_wack = 1'b1;
      end
      @(posedge clk); #1;
      m_rack = 1'b0; m_wack = 1'b0;
      check("en_hold", 64'(m_re | m_we), 64'd1);
      check("early_ack", 64'({co_wack, co_rack}), 64'd0);
    end
    if (e.is_wr) m_wack = 1'b1;
    else begin m_rack = 1'b1; m_rdata = v.rdata; end
    @(posedge clk); #1;
    m_rack = 1'b0; m_wack = 1'b0; m_rdata = '0;
    co_re = '0; co_we = '0;
    if (!e.is_wr) exp_din[e.port] = v.rdata;
    check("ack_port", 64'({co_wack, co_rack}), 64'd1 << e.port);
    check("en_drop", 64'(m_re | m_we), 64'd0);
    for (int i = 0; i < NR; i++) check("co_din", 64'(co_din[i*DATA_W +: DATA_W]), 64'(exp_din[i]));
    @(posedge clk); #1;
    check("ack_pulse", 64'({co_wack, co_rack}), 64'd0);
  endtask

  function automatic logic [ADDR_W-1:0] cont_addr(input int port);
    return (port == 0) ? 32'h10 : (port == 1) ? 32'h20 : 32'h30;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   grants, cyc, last, nacks;

    vecs[0] = mk(2'b01, 1'b0, 32'h100, 2, 32'h0, 0, 32'h0, 0, 32'h0, 32'hDEADBEEF, 3, 0, 0, 0);
    vecs[1] = mk(2'b00, 1'b1, 32'h0, 0, 32'h0, 0, 32'h2000, 0, 32'h12345678, 32'h0, 1, 2, 0, 0);
    vecs[2] = mk(2'b10, 1'b0, 32'h0, 0, 32'h204, 1, 32'h0, 0, 32'h0, 32'hCAFEF00D, 0, 1, 0, 0);
    vecs[3] = mk(2'b11, 1'b0, 32'h300, 2, 32'h304, 1, 32'h0, 0, 32'h0, 32'h11112222, 2, 0, 0, 0);
    vecs[4] = mk(2'b11, 1'b0, 32'h400, 0, 32'h404, 2, 32'h0, 0, 32'h0, 32'h33334444, 0, 1, 0, 0);
    vecs[5] = mk(2'b01, 1'b1, 32'h500, 1, 32'h0, 0, 32'h5000, 1, 32'hA5A5A5A5, 32'h0, 0, 2, 0, 0);
    vecs[6] = mk(2'b01, 1'b1, 32'h600, 0, 32'h0, 0, 32'h6000, 2, 32'h0F0F0F0F, 32'h55556666, 1,
                 WPRIO ? 2 : 0, 0, 0);
    vecs[7] = mk(2'b10, 1'b0, 32'h0, 0, 32'h7000, 2, 32'h0, 0, 32'h0, 32'h99990000, 2, 1, 1, 1);

    do_reset();
    check("rst_m_re",    64'(m_re), 64'd0);
    check("rst_m_we",    64'(m_we), 64'd0);
    check("rst_acks",    64'({co_wack, co_rack}), 64'd0);
    check("rst_co_din",  64'(co_din), 64'd0);
    check("rst_m_raddr", 64'(m_raddr), 64'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Contention: all requests held continuously, controller acks immediately.
    do_reset();
    co_raddr = {32'h20, 32'h10}; co_waddr = 32'h30; co_re = '1; co_we = '1;
    for (int g = 0; g < 4; g++) begin
      e.port  = WPRIO ? 2 : (g % 3);
      e.is_wr = (e.port >= NR);
      e.addr  = cont_addr(e.port);
      sb.push_back(e);
    end
    grants = 0; cyc = 0; last = 0; nacks = 0;
    while (grants < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      m_rack = 1'b0; m_wack = 1'b0;
      if ({co_wack, co_rack} != '0) begin
        nacks++;
        check("cont_ack", 64'({co_wack, co_rack}), 64'd1 << last);
      end
      if (m_re || m_we) begin
        e = sb.pop_front();
        check("cont_kind", 64'(m_we), 64'(e.is_wr));
        check("cont_addr", 64'(m_we ? m_waddr : m_raddr), 64'(e.addr));
        last = e.port;
        grants++;
        if (m_re) m_rack = 1'b1; else m_wack = 1'b1;
      end
    end
    @(posedge clk); #1;
    m_rack = 1'b0; m_wack = 1'b0; co_re = '0; co_we = '0;
    if ({co_wack, co_rack} != '0) begin
      nacks++;
      check("cont_ack", 64'({co_wack, co_rack}), 64'd1 << last);
    end
    repeat (2) begin
      @(posedge clk); #1;
      if ({co_wack, co_rack} != '0) nacks++;
    end
    check("cont_grants", 64'(grants), 64'd4);
    check("cont_nacks",  64'(nacks),  64'd4);
    sb.delete();

    // Mid-transaction reset: move the pointer to r1, then reset while r0 is busy.
    do_reset();
    run_vec(mk(2'b01, 1'b0, 32'h800, 2, 32'h0, 0, 32'h0, 0, 32'h0, 32'h77778888, 0, 0, 0, 0));
    @(posedge clk); #1;
    co_re = 2'b01; co_raddr = {32'h0, 32'h810};
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!m_re && cyc < 20);
    check("mr_en", 64'(m_re), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mr_m_re", 64'(m_re), 64'd0);
    check("mr_m_we", 64'(m_we), 64'd0);
    rst = 1'b0; co_re = '0; m_rack = 1'b1; m_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < NR; i++) exp_din[i] = '0;
    @(posedge clk); #1;
    m_rack = 1'b0; m_rdata = '0;
    check("mr_no_ack", 64'({co_wack, co_rack}), 64'd0);
    @(posedge clk); #1;
    check("mr_no_ack2", 64'({co_wack, co_rack}), 64'd0);
    check("mr_idle", 64'(m_re | m_we), 64'd0);
    run_vec(mk(2'b11, 1'b0, 32'h900, 1, 32'h904, 2, 32'h0, 0, 32'h0, 32'hABCD0123, 1, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
